// File: rtl/pixel_sequencer.sv
// Frame sequencer for NPIX pixel sensors that share one DATA bus.
// One frame runs erase, expose, ramp conversion and a handshaked readout of every pixel.
module pixel_sequencer #(
    parameter int NPIX     = 4,
    parameter int DW       = 8,
    parameter int C_ERASE  = 4,
    parameter int C_EXPOSE = 255,
    parameter int C_RAMP   = 256,
    localparam int IW      = (NPIX > 1) ? $clog2(NPIX) : 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            START,
    output logic            ERASE,
    output logic            EXPOSE,
    output logic            RAMP,
    output logic [NPIX-1:0] READ,
    inout  wire  [DW-1:0]   DATA,
    output logic [DW-1:0]   PX_DATA,
    output logic [IW-1:0]   PX_IDX,
    output logic            PX_VALID,
    input  logic            PX_READY,
    output logic            BUSY,
    output logic            DONE
);

    localparam int TMAX = (C_EXPOSE > C_ERASE) ? C_EXPOSE : C_ERASE;
    localparam int TW   = $clog2(TMAX) + 1;
    localparam int KW   = $clog2(C_RAMP) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE,
        S_EXPOSE,
        S_CONVERT,
        S_TURN,
        S_RD_SEL,
        S_RD_OUT,
        S_FIN
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic [KW-1:0]   step;
    logic            phase_b;
    logic [IW-1:0]   pix;
    logic            drive;
    logic [DW-1:0]   data_out;

    // Only this register pair can put the sequencer on the bus, and both clear asynchronously.
    assign DATA = drive ? data_out : {DW{1'bz}};

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            timer    <= '0;
            step     <= '0;
            phase_b  <= 1'b0;
            pix      <= '0;
            drive    <= 1'b0;
            data_out <= '0;
            ERASE    <= 1'b0;
            EXPOSE   <= 1'b0;
            RAMP     <= 1'b0;
            READ     <= '0;
            PX_DATA  <= '0;
            PX_IDX   <= '0;
            PX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        state <= S_ERASE;
                        ERASE <= 1'b1;
                        BUSY  <= 1'b1;
                        timer <= TW'(C_ERASE - 1);
                    end
                end
                S_ERASE: begin
                    if (timer == '0) begin
                        state  <= S_EXPOSE;
                        ERASE  <= 1'b0;
                        EXPOSE <= 1'b1;
                        timer  <= TW'(C_EXPOSE - 1);
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                S_EXPOSE: begin
                    if (timer == '0) begin
                        state    <= S_CONVERT;
                        EXPOSE   <= 1'b0;
                        RAMP     <= 1'b1;
                        drive    <= 1'b1;
                        step     <= '0;
                        phase_b  <= 1'b0;
                        data_out <= '0;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end
                // Each step is a RAMP-high cycle followed by a RAMP-low cycle with the count held.
                S_CONVERT: begin
                    if (!phase_b) begin
                        RAMP    <= 1'b0;
                        phase_b <= 1'b1;
                    end else if (step == KW'(C_RAMP - 1)) begin
                        state    <= S_TURN;
                        drive    <= 1'b0;
                        data_out <= '0;
                        phase_b  <= 1'b0;
                    end else begin
                        step     <= step + KW'(1);
                        phase_b  <= 1'b0;
                        RAMP     <= 1'b1;
                        data_out <= DW'(step + KW'(1));
                    end
                end
                S_TURN: begin
                    state <= S_RD_SEL;
                    pix   <= '0;
                    READ  <= NPIX'(1);
                end
                // The selected pixel has had a full cycle to settle the bus before capture.
                S_RD_SEL: begin
                    state    <= S_RD_OUT;
                    PX_DATA  <= DATA;
                    PX_IDX   <= pix;
                    PX_VALID <= 1'b1;
                end
                S_RD_OUT: begin
                    if (PX_READY) begin
                        PX_VALID <= 1'b0;
                        if (pix == IW'(NPIX - 1)) begin
                            state <= S_FIN;
                            READ  <= '0;
                            DONE  <= 1'b1;
                        end else begin
                            state <= S_RD_SEL;
                            pix   <= pix + IW'(1);
                            READ  <= READ << 1;
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_sequencer.sv
// Self-checking bench for pixel_sequencer: a frame-timeline model checked every cycle,
// pixel models on the shared bus, and directed frame scenarios with literal expectations.
module tb_pixel_sequencer;

    localparam int NPIX = 4;
    localparam int DW   = 8;
    localparam int CE   = 4;
    localparam int CX   = 255;
    localparam int CR   = 256;
    localparam int IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam int T_TURN = CE + CX + 2 * CR;
    localparam logic [DW-1:0] BUS_IDLE = '1;
    localparam logic [DW-1:0] NO_CODE  = 8'hEE;
    localparam logic [DW-1:0] CODE [NPIX] = '{8'd10, 8'd20, 8'd30, 8'd40};

    logic            CLK = 1'b0;
    logic            RESET = 1'b0;
    logic            START = 1'b0;
    logic            PX_READY = 1'b1;
    logic            ERASE, EXPOSE, RAMP, PX_VALID, BUSY, DONE;
    logic [NPIX-1:0] READ;
    logic [DW-1:0]   PX_DATA;
    logic [IW-1:0]   PX_IDX;
    wire  [DW-1:0]   DATA;

    int tests = 0;
    int fails = 0;

    pixel_sequencer #(
        .NPIX(NPIX), .DW(DW), .C_ERASE(CE), .C_EXPOSE(CX), .C_RAMP(CR)
    ) dut (
        .CLK(CLK), .RESET(RESET), .START(START),
        .ERASE(ERASE), .EXPOSE(EXPOSE), .RAMP(RAMP), .READ(READ),
        .DATA(DATA),
        .PX_DATA(PX_DATA), .PX_IDX(PX_IDX), .PX_VALID(PX_VALID), .PX_READY(PX_READY),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CLK = ~CLK;

    // The bus is pulled high, so a released bus reads all ones.
    pullup (DATA);

    logic [DW-1:0] latched [NPIX];
    logic          pix_en;
    logic [DW-1:0] pix_val;

    always_comb begin
        pix_en  = 1'b0;
        pix_val = '0;
        for (int i = 0; i < NPIX; i++) begin
            if (READ[i]) begin
                pix_en  = 1'b1;
                pix_val = latched[i];
            end
        end
    end

    assign DATA = pix_en ? pix_val : {DW{1'bz}};

    typedef struct {
        logic            erase;
        logic            expose;
        logic            ramp;
        logic [NPIX-1:0] read;
        logic [DW-1:0]   data;
        logic            pxv;
        logic [DW-1:0]   pxd;
        logic [IW-1:0]   pxi;
        logic            busy;
        logic            done;
    } exp_t;

    function automatic exp_t idle_exp();
        exp_t e;
        e.erase = 1'b0; e.expose = 1'b0; e.ramp = 1'b0; e.read = '0;
        e.data = BUS_IDLE; e.pxv = 1'b0; e.pxd = '0; e.pxi = '0;
        e.busy = 1'b0; e.done = 1'b0;
        return e;
    endfunction

    function automatic int frame_len(int s);
        return T_TURN + 2 + NPIX * (2 + s);
    endfunction

    // Outputs j cycles after the START sample, with s stall cycles at every pixel.
    function automatic exp_t exp_at(int j, int s);
        exp_t e;
        int r, p, q;
        e = idle_exp();
        e.busy = 1'b1;
        if (j < CE) begin
            e.erase = 1'b1;
        end else if (j < CE + CX) begin
            e.expose = 1'b1;
        end else if (j < T_TURN) begin
            r = j - CE - CX;
            e.ramp = (r % 2 == 0);
            e.data = DW'(r / 2);
        end else if (j > T_TURN && j < T_TURN + 1 + NPIX * (2 + s)) begin
            r = j - T_TURN - 1;
            p = r / (2 + s);
            q = r % (2 + s);
            e.read = NPIX'(1) << p;
            e.data = CODE[p];
            if (q > 0) begin
                e.pxv = 1'b1;
                e.pxd = CODE[p];
                e.pxi = IW'(p);
            end
        end else if (j == T_TURN + 1 + NPIX * (2 + s)) begin
            e.done = 1'b1;
        end
        return e;
    endfunction

    bit m_active = 1'b0;
    int m_j = 0;
    int m_s = 0;
    int stall = 0;
    int wait_cnt = 0;
    int cyc = 0;

    int erase_cnt, expose_cnt, ramp_cnt, ramp_bad, done_cyc;
    bit saw_done;
    logic [DW-1:0] acc_d [$];
    logic [IW-1:0] acc_i [$];

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        exp_t e;
        bit bad;
        e = (RESET && m_active) ? exp_at(m_j, m_s) : idle_exp();
        bad = (ERASE !== e.erase) || (EXPOSE !== e.expose) || (RAMP !== e.ramp) ||
              (READ !== e.read) || (DATA !== e.data) || (PX_VALID !== e.pxv) ||
              (BUSY !== e.busy) || (DONE !== e.done) ||
              (e.pxv && ((PX_DATA !== e.pxd) || (PX_IDX !== e.pxi)));
        tests++;
        if (bad) begin
            fails++;
            if (fails <= 20)
                $display("[TB] FAIL cycle_model j=%0d: got er=%b ex=%b rp=%b rd=%b d=%0d v=%b pd=%0d pi=%0d bsy=%b dn=%b, expected er=%b ex=%b rp=%b rd=%b d=%0d v=%b pd=%0d pi=%0d bsy=%b dn=%b",
                         m_j, ERASE, EXPOSE, RAMP, READ, DATA, PX_VALID, PX_DATA, PX_IDX, BUSY, DONE,
                         e.erase, e.expose, e.ramp, e.read, e.data, e.pxv, e.pxd, e.pxi, e.busy, e.done);
        end
    endtask

    // One clock cycle: advance the model across the coming edge, then check and react at the negedge.
    task automatic apply_stimulus();
        if (!RESET) begin
            m_active = 1'b0;
        end else if (m_active) begin
            m_j++;
            if (m_j == frame_len(m_s)) m_active = 1'b0;
        end else if (START) begin
            m_active = 1'b1;
            m_j = 0;
            m_s = stall;
        end
        @(negedge CLK);
        cyc++;
        compare_model();
        if (ERASE) begin
            erase_cnt++;
            for (int i = 0; i < NPIX; i++) latched[i] = NO_CODE;
        end
        if (EXPOSE) expose_cnt++;
        if (RAMP) begin
            if (DATA !== DW'(ramp_cnt)) ramp_bad++;
            ramp_cnt++;
            for (int i = 0; i < NPIX; i++)
                if (DATA == CODE[i]) latched[i] = DATA;
        end
        if (DONE) begin
            saw_done = 1'b1;
            done_cyc = cyc;
        end
        if (PX_VALID && wait_cnt < stall) begin
            PX_READY = 1'b0;
            wait_cnt++;
        end else begin
            PX_READY = 1'b1;
            wait_cnt = 0;
        end
        if (PX_VALID && PX_READY) begin
            acc_d.push_back(PX_DATA);
            acc_i.push_back(PX_IDX);
        end
    endtask

    task automatic clear_monitors();
        erase_cnt = 0; expose_cnt = 0; ramp_cnt = 0; ramp_bad = 0;
        saw_done = 1'b0; done_cyc = 0;
        acc_d.delete();
        acc_i.delete();
    endtask

    task automatic wait_done(output bit ok);
        int n;
        n = 0;
        saw_done = 1'b0;
        while (!saw_done && n < 3000) begin
            apply_stimulus();
            n++;
        end
        ok = saw_done;
    endtask

    task automatic kick_frame(input int s, output int t0);
        clear_monitors();
        stall = s;
        START = 1'b1;
        t0 = cyc;
        apply_stimulus();
        START = 1'b0;
    endtask

    task automatic finish_frame(input int t0, input int lat);
        bit ok;
        wait_done(ok);
        check_output("done_seen", ok, 1);
        check_output("frame_latency", done_cyc - t0 + 1, lat);
        check_output("erase_cycles", erase_cnt, CE);
        check_output("expose_cycles", expose_cnt, CX);
        check_output("ramp_pulses", ramp_cnt, CR);
        check_output("ramp_data_errors", ramp_bad, 0);
        check_output("pixels_accepted", acc_d.size(), NPIX);
        for (int n = 0; n < NPIX && n < acc_d.size(); n++) begin
            check_output("px_data", acc_d[n], CODE[n]);
            check_output("px_idx", acc_i[n], n);
        end
        apply_stimulus();
        check_output("busy_after_frame", BUSY, 0);
    endtask

    task automatic run_frame(input int s, input int lat);
        int t0;
        kick_frame(s, t0);
        finish_frame(t0, lat);
    endtask

    task automatic reset_now();
        #2 RESET = 1'b0;
        #1;
        check_output("rst_ramp", RAMP, 0);
        check_output("rst_read", READ, 0);
        check_output("rst_px_valid", PX_VALID, 0);
        check_output("rst_data_released", DATA, BUS_IDLE);
        check_output("rst_busy", BUSY, 0);
        m_active = 1'b0;
        repeat (2) apply_stimulus();
        #2 RESET = 1'b1;
        repeat (3) apply_stimulus();
    endtask

    initial begin
        int t0, n, erase_cyc, first_done;
        bit ok;
        for (int i = 0; i < NPIX; i++) latched[i] = NO_CODE;
        clear_monitors();

        #3;
        check_output("init_erase", ERASE, 0);
        check_output("init_expose", EXPOSE, 0);
        check_output("init_ramp", RAMP, 0);
        check_output("init_read", READ, 0);
        check_output("init_data_released", DATA, BUS_IDLE);
        check_output("init_px_data", PX_DATA, 0);
        check_output("init_px_idx", PX_IDX, 0);
        check_output("init_px_valid", PX_VALID, 0);
        check_output("init_busy", BUSY, 0);
        check_output("init_done", DONE, 0);
        repeat (2) apply_stimulus();
        #2 RESET = 1'b1;
        for (int i = 0; i < 10; i++) begin
            apply_stimulus();
            check_output("idle_busy", BUSY, 0);
        end

        $display("[TB] nominal frame");
        run_frame(0, 782);

        $display("[TB] backpressure frame");
        run_frame(5, 782 + NPIX * 5);

        $display("[TB] start pulse during expose");
        kick_frame(0, t0);
        repeat (100) apply_stimulus();
        check_output("in_expose", EXPOSE, 1);
        START = 1'b1;
        apply_stimulus();
        START = 1'b0;
        finish_frame(t0, 782);

        $display("[TB] start held high");
        kick_frame(0, t0);
        START = 1'b1;
        wait_done(ok);
        check_output("held_first_done", ok, 1);
        check_output("held_first_latency", done_cyc - t0 + 1, 782);
        first_done = done_cyc;
        n = 0;
        erase_cyc = 0;
        while (!ERASE && n < 5) begin
            apply_stimulus();
            n++;
        end
        if (ERASE) erase_cyc = cyc;
        START = 1'b0;
        check_output("idle_gap", erase_cyc - first_done, 2);
        wait_done(ok);
        check_output("held_second_done", ok, 1);
        check_output("held_second_latency", done_cyc - (first_done + 1) + 1, 782);
        repeat (2) apply_stimulus();

        $display("[TB] reset during convert");
        kick_frame(0, t0);
        n = 0;
        while (!(RAMP && DATA == 8'd100) && n < 1000) begin
            apply_stimulus();
            n++;
        end
        check_output("reached_step_100", DATA, 100);
        reset_now();
        run_frame(0, 782);

        $display("[TB] reset during readout");
        kick_frame(5, t0);
        n = 0;
        while (!(PX_VALID && PX_IDX == 2) && n < 1000) begin
            apply_stimulus();
            n++;
        end
        check_output("reached_pixel_2", PX_IDX, 2);
        reset_now();
        run_frame(3, 782 + NPIX * 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
